// File: rtl/lab3_selftest.sv
// Built-in self-test sequencer for a 3-input gate block: walks all 8 input
// vectors, compares dut_x/dut_y against the reference gate equations and reports.
module lab3_selftest #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_x,
  input  logic       dut_y,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_fail,
  output logic       first_fail_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(SETTLE - 1);

  state_t     r_state;
  logic [2:0] r_idx;
  logic [3:0] r_wait_cnt;
  logic       r_dut_a;
  logic       r_dut_b;
  logic       r_dut_c;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_err_count;
  logic [2:0] r_first_fail;
  logic       r_first_fail_valid;

  logic       w_x_exp;
  logic       w_y_exp;
  logic       w_mismatch;
  logic [3:0] w_err_next;
  logic [2:0] w_idx_next;

  // Reference model of the gate block, evaluated on the vector currently driven.
  assign w_x_exp    = (~r_dut_c) ^ (r_dut_a | r_dut_b);
  assign w_y_exp    = r_dut_a & r_dut_b;
  assign w_mismatch = (dut_x != w_x_exp) || (dut_y != w_y_exp);
  assign w_err_next = r_err_count + {3'b000, w_mismatch};
  assign w_idx_next = r_idx + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state            <= S_IDLE;
      r_idx              <= '0;
      r_wait_cnt         <= '0;
      r_dut_a            <= 1'b0;
      r_dut_b            <= 1'b0;
      r_dut_c            <= 1'b0;
      r_busy             <= 1'b0;
      r_done             <= 1'b0;
      r_pass             <= 1'b0;
      r_err_count        <= '0;
      r_first_fail       <= '0;
      r_first_fail_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults are overridden by later assignments in the same edge.
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state                       <= S_DRIVE;
            r_idx                         <= '0;
            {r_dut_a, r_dut_b, r_dut_c}   <= 3'b000;
            r_busy                        <= 1'b1;
            r_pass                        <= 1'b0;
            r_err_count                   <= '0;
            r_first_fail                  <= '0;
            r_first_fail_valid            <= 1'b0;
          end
        end
        S_DRIVE: begin
          r_state    <= S_WAIT;
          r_wait_cnt <= WAIT_LAST;
        end
        S_WAIT: begin
          if (r_wait_cnt == 4'd0) r_state <= S_CHECK;
          else                    r_wait_cnt <= r_wait_cnt - 4'd1;
        end
        S_CHECK: begin
          if (w_mismatch) begin
            r_err_count <= w_err_next;
            if (!r_first_fail_valid) begin
              r_first_fail       <= r_idx;
              r_first_fail_valid <= 1'b1;
            end
          end
          if (r_idx == 3'd7) begin
            r_state                     <= S_DONE;
            {r_dut_a, r_dut_b, r_dut_c} <= 3'b000;
            r_busy                      <= 1'b0;
            r_done                      <= 1'b1;
            r_pass                      <= (w_err_next == 4'd0);
          end else begin
            r_state                     <= S_DRIVE;
            r_idx                       <= w_idx_next;
            {r_dut_a, r_dut_b, r_dut_c} <= w_idx_next;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dut_a            = r_dut_a;
  assign dut_b            = r_dut_b;
  assign dut_c            = r_dut_c;
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign err_count        = r_err_count;
  assign first_fail       = r_first_fail;
  assign first_fail_valid = r_first_fail_valid;

endmodule

// File: tb/tb_lab3_selftest.sv
// Self-checking bench for lab3_selftest: a SETTLE=2 instance against a gate model
// with injectable stuck-at faults, and a SETTLE=1 instance against a correct model.
module tb_lab3_selftest;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, start_b;
  logic fault_x0, fault_y0;

  logic       a_x, a_y, a_a, a_b, a_c, a_busy, a_done, a_pass, a_ffv;
  logic [3:0] a_err;
  logic [2:0] a_ff;
  logic       b_x, b_y, b_a, b_b, b_c, b_busy, b_done, b_pass, b_ffv;
  logic [3:0] b_err;
  logic [2:0] b_ff;

  typedef struct packed {
    logic [3:0] err;
    logic [2:0] ff;
    logic       ffv;
    logic       pass;
  } res_t;

  res_t       exp_q[$];
  logic [2:0] vec_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  // Gate blocks under test, with optional stuck-at-0 faults on instance A.
  assign a_x = fault_x0 ? 1'b0 : ((~a_c) ^ (a_a | a_b));
  assign a_y = fault_y0 ? 1'b0 : (a_a & a_b);
  assign b_x = (~b_c) ^ (b_a | b_b);
  assign b_y = b_a & b_b;

  lab3_selftest #(.SETTLE(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .dut_x(a_x), .dut_y(a_y),
    .dut_a(a_a), .dut_b(a_b), .dut_c(a_c), .busy(a_busy), .done(a_done),
    .pass(a_pass), .err_count(a_err), .first_fail(a_ff), .first_fail_valid(a_ffv)
  );

  lab3_selftest #(.SETTLE(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dut_x(b_x), .dut_y(b_y),
    .dut_a(b_a), .dut_b(b_b), .dut_c(b_c), .busy(b_busy), .done(b_done),
    .pass(b_pass), .err_count(b_err), .first_fail(b_ff), .first_fail_valid(b_ffv)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outcome of a full run given which fault is injected.
  function automatic res_t model_run(input bit fx, input bit fy);
    res_t       r;
    logic [2:0] v;
    logic       xe, ye, xo, yo;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      v  = 3'(i);
      xe = (~v[0]) ^ (v[2] | v[1]);
      ye = v[2] & v[1];
      xo = fx ? 1'b0 : xe;
      yo = fy ? 1'b0 : ye;
      if ((xo != xe) || (yo != ye)) begin
        if (!r.ffv) begin
          r.ff  = v;
          r.ffv = 1'b1;
        end
        r.err = r.err + 4'd1;
      end
    end
    r.pass = (r.err == 4'd0);
    return r;
  endfunction

  task automatic check_result(input string tag);
    res_t r;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
    end else begin
      r = exp_q.pop_front();
      check({tag, "_err"},  a_err,  r.err);
      check({tag, "_ff"},   a_ff,   r.ff);
      check({tag, "_ffv"},  a_ffv,  r.ffv);
      check({tag, "_pass"}, a_pass, r.pass);
    end
  endtask

  // Starts a run on instance A and returns the edge index at which done rose.
  task automatic run_a(input string tag, input bit fx, input bit fy, output int edges);
    fault_x0 = fx;
    fault_y0 = fy;
    exp_q.push_back(model_run(fx, fy));
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check({tag, "_busy0"},  a_busy, 1'b1);
    check({tag, "_clr"},    {a_err, a_ffv, a_pass}, 6'b0);
    edges = -1;
    for (int e = 1; e <= 200; e++) begin
      tick();
      if (a_done) begin
        edges = e;
        break;
      end
    end
    check({tag, "_edge"}, edges, 32);
  endtask

  initial begin
    int edges;
    int dones;
    int first_done;

    rst_n    = 1'b0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    fault_x0 = 1'b0;
    fault_y0 = 1'b0;
    tick();
    tick();
    check("reset_a", {a_a, a_b, a_c, a_busy, a_done, a_pass, a_err, a_ff, a_ffv}, 0);
    check("reset_b", {b_a, b_b, b_c, b_busy, b_done, b_pass, b_err, b_ff, b_ffv}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Correct gate block.
    run_a("good", 1'b0, 1'b0, edges);
    check("good_busy_at_done", a_busy, 1'b0);
    check("good_abc_at_done", {a_a, a_b, a_c}, 3'b000);
    check_result("good");
    tick();
    check("good_done_pulse", a_done, 1'b0);
    tick();
    tick();
    check("good_hold", {a_pass, a_err, a_ffv}, {1'b1, 4'd0, 1'b0});

    // dut_y stuck at 0.
    run_a("ystuck", 1'b0, 1'b1, edges);
    check_result("ystuck");
    check("ystuck_err_const", {a_err, a_ff, a_pass}, {4'd2, 3'd6, 1'b0});
    tick();

    // dut_x stuck at 0.
    run_a("xstuck", 1'b1, 1'b0, edges);
    check_result("xstuck");
    check("xstuck_err_const", {a_err, a_ff, a_pass}, {4'd4, 3'd0, 1'b0});
    tick();

    // start pulsed while vector 3 is in flight must be ignored.
    fault_x0 = 1'b0;
    fault_y0 = 1'b0;
    exp_q.push_back(model_run(1'b0, 1'b0));
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    dones = 0;
    first_done = -1;
    for (int e = 1; e <= 70; e++) begin
      if (e == 13) start_a = 1'b1;
      if (e == 14) start_a = 1'b0;
      tick();
      if (e == 13) check("midpulse_vec3", {a_a, a_b, a_c}, 3'd3);
      if (a_done) begin
        dones++;
        if (first_done < 0) first_done = e;
      end
      if (e == 32) check_result("midpulse");
    end
    check("midpulse_done_count", dones, 1);
    check("midpulse_done_edge", first_done, 32);

    // Asynchronous reset during WAIT of vector 4 aborts the run.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int e = 1; e <= 17; e++) tick();
    check("prereset_state", {a_a, a_b, a_c, a_busy}, 4'b1001);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {a_a, a_b, a_c, a_busy, a_done, a_pass, a_err, a_ff, a_ffv}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int e = 0; e < 60; e++) begin
      tick();
      if (a_done || a_busy) dones++;
    end
    check("no_resume", dones, 0);
    run_a("after_reset", 1'b0, 1'b0, edges);
    check_result("after_reset");
    tick();

    // SETTLE=1: each vector held 3 cycles, done at edge 24.
    for (int e = 0; e < 24; e++) vec_q.push_back(3'(e / 3));
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int e = 0; e < 24; e++) begin
      if (e > 0) tick();
      check("s1_vec", {b_a, b_b, b_c}, vec_q.pop_front());
      check("s1_nodone", b_done, 1'b0);
    end
    tick();
    check("s1_done_edge24", {b_done, b_busy, b_a, b_b, b_c}, 5'b10000);
    check("s1_result", {b_pass, b_err, b_ffv}, {1'b1, 4'd0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lab3_selftest.md
LAB3_SELFTEST -- requirements
Module: lab3_selftest

Interface
REQ-001 SHALL have parameter SETTLE, default 2, giving the cycles between driving a vector and sampling the response; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, which requests one full 8-vector self-test run.
REQ-005 SHALL have ports dut_x and dut_y, input, 1 each, the responses from the gate block under test.
REQ-006 SHALL have ports dut_a, dut_b and dut_c, output, 1 each, the registered stimulus to the gate block under test.
REQ-007 SHALL have port busy, output, 1, high while a run is in progress.
REQ-008 SHALL have port done, output, 1, a one-cycle pulse at the end of a run.
REQ-009 SHALL have port pass, output, 1, high when the last completed run had zero mismatches.
REQ-010 SHALL have port err_count, output, 4, the number of mismatching vectors in the current or last run.
REQ-011 SHALL have ports first_fail (output, 3) and first_fail_valid (output, 1), giving the index of the first mismatching vector.

Function
REQ-012 SHALL implement the FSM states IDLE, DRIVE, WAIT, CHECK and DONE.
REQ-013 SHALL transition IDLE->DRIVE on the edge where start=1; start SHALL be ignored in every other state.
REQ-014 SHALL, on the edge entering DRIVE for vector idx (0..7), register dut_a=idx[2], dut_b=idx[1], dut_c=idx[0], holding them until the next DRIVE or DONE entry.
REQ-015 SHALL go DRIVE->WAIT after 1 cycle, stay in WAIT for exactly SETTLE cycles, then go WAIT->CHECK.
REQ-016 SHALL, in CHECK, compute expected values x_exp = (~c) XOR (a OR b) and y_exp = a AND b from the driven vector.
REQ-017 SHALL, in CHECK, flag a mismatch when dut_x != x_exp or dut_y != y_exp; one vector counts at most 1 error.
REQ-018 SHALL, on a mismatch, increment err_count (max 8, so no wrap); on the first mismatch of a run it SHALL load first_fail=idx and set first_fail_valid=1.
REQ-019 SHALL go CHECK->DRIVE with idx+1 when idx<7, and CHECK->DONE when idx=7.
REQ-020 SHALL, on the edge entering DONE, drive dut_a/b/c to 0 and update pass=(err_count==0 including the final vector).
REQ-021 SHALL assert done for the single DONE cycle, then return to IDLE.
REQ-022 SHALL hold busy=1 in DRIVE, WAIT and CHECK, and busy=0 in IDLE and DONE.
REQ-023 SHALL, with the edge sampling start counted as edge 0, have DONE entered at edge 8*(SETTLE+2).
REQ-024 SHALL, on the edge accepting start, clear err_count, first_fail, first_fail_valid, pass and idx.
REQ-025 SHALL hold pass, err_count and first_fail* after DONE until the next accepted start.
REQ-026 SHALL, for start=1 held continuously, begin a new run from the IDLE cycle following DONE.

Reset
REQ-027 SHALL, when rst_n=0 at any time including mid-run, immediately force state=IDLE, idx=0, dut_a/b/c=0, busy=0, done=0, pass=0, err_count=0, first_fail=0 and first_fail_valid=0.
REQ-028 SHALL, after rst_n is released mid-run, not resume the aborted run; a new start is required.

Verification
REQ-029 SHALL cover a correct gate-model DUT with SETTLE=2 -> done high in the cycle after edge 32, pass=1, err_count=0, first_fail_valid=0.
REQ-030 SHALL cover a DUT with dut_y stuck at 0 -> err_count=2, first_fail=6, pass=0.
REQ-031 SHALL cover a DUT with dut_x stuck at 0 -> err_count=4 (vectors 0,3,5,7), first_fail=0, pass=0.
REQ-032 SHALL cover start pulsed during vector 3 of a run -> the run is unaffected and done occurs exactly once.
REQ-033 SHALL cover rst_n dropped during WAIT of vector 4 -> all outputs 0 asynchronously and no done until the next start.
REQ-034 SHALL cover SETTLE=1 with a correct DUT -> done at edge 24 and dut_a/b/c stepping through 000..111 with each vector held 3 cycles.
